sdi_xcvr_rx_lock_supervisor: RTL and testbench
==============================================

Name: sdi_xcvr_rx_lock_supervisor

Overview:
- Supervises the SDI receive transceiver link and sits beside the S10 transceiver reset controller.
- Consumes rx_ready from the reset controller, plus rx_is_lockedtodata and the SDI core lock flag.
- Drives the reset controller's reset input. It re-initialises the RX path after a persistent lock loss, or when the link fails to come up within a timeout.
- Exposes link status and a retry counter for the status registers.

Parameters:
RESET_PULSE_CYCLES, 16, cycles xcvr_reset is held high per supervisor-issued reset (>=2)
READY_TIMEOUT_CYCLES, 1000000, max cycles in WAIT_READY before a retry reset (>=2)
LOCK_LOSS_CYCLES, 1024, consecutive bad cycles in LINK_UP that trigger a reset (>=1)
CNT_W, 24, width of shared timer; must hold max(all cycle parameters)

Ports:
clock  in  1  system clock, same clock as the reset controller
reset  in  1  synchronous, active-high
enable  in  1  supervisor enable; low holds the RX transceiver in reset
rx_ready  in  1  from reset controller, synchronous to clock
rx_is_lockedtodata  in  1  CDR lock from transceiver, asynchronous
sdi_locked  in  1  SDI RX core lock, asynchronous
clear_count  in  1  single-cycle pulse, zeroes reset_count
xcvr_reset  out  1  drives reset controller reset input
link_up  out  1  high while in LINK_UP
state  out  2  0=IDLE, 1=RST, 2=WAIT_READY, 3=LINK_UP
reset_count  out  8  supervisor-issued resets, saturating

Behaviour:
- Inputs rx_is_lockedtodata and sdi_locked each pass through a 2-flop synchroniser, adding 2 cycles of latency. rx_ready is used directly.
- good = rx_ready & lock_s & sdi_s; bad = !good.
- All outputs are registered, decoded from the state register:
  - xcvr_reset = (state==IDLE) | (state==RST).
  - link_up = (state==LINK_UP).
- Reset values: state=RST, xcvr_reset=1, link_up=0, reset_count=0, timer=0, synchroniser flops=0.
- Any state, enable=0: next state IDLE, timer=0. This takes priority over every other transition. No reset_count increment.
- IDLE: when enable=1, go to RST with timer=0 and no increment.
- RST: timer increments each cycle. When timer==RESET_PULSE_CYCLES-1, go to WAIT_READY with timer=0. xcvr_reset is therefore high for exactly RESET_PULSE_CYCLES cycles.
- WAIT_READY:
  - good -> LINK_UP (timer=0).
  - Else, if timer==READY_TIMEOUT_CYCLES-1 -> RST (timer=0) and reset_count increments.
  - Else timer increments.
  - good on the timeout cycle wins: go to LINK_UP, no increment.
- LINK_UP:
  - timer counts consecutive bad cycles; any good cycle clears it to 0.
  - On a bad cycle with timer==LOCK_LOSS_CYCLES-1 -> RST (timer=0) and reset_count increments.
  - link_up deasserts the cycle after the LOCK_LOSS_CYCLES-th consecutive bad cycle.
- reset_count saturates at 255.
  - clear_count=1 sets it to 0.
  - clear_count and an increment in the same cycle -> result 0 (clear wins).
- Reset asserted mid-operation (any state): forces reset values next cycle. A reset-forced RST entry never counts.
- Timer must not wrap. It is bounded by the transition compares above.

Test Plan (sim params RESET_PULSE_CYCLES=16, READY_TIMEOUT_CYCLES=64, LOCK_LOSS_CYCLES=8):
1. Release reset with enable=1 and all inputs good -> xcvr_reset high 16 cycles, then state=2. link_up=1 one cycle after the first good cycle in WAIT_READY. reset_count=0.
2. In LINK_UP, drop sdi_locked for 7 cycles then restore -> link_up stays 1 and reset_count=0. Drop it for 8+ cycles -> link_up falls 8 cycles after the synchronised drop, xcvr_reset pulses 16 cycles, reset_count=1.
3. Hold rx_ready=0 after reset -> WAIT_READY times out after 64 cycles. Repeated RST/WAIT loops occur; reset_count reaches 3 after 3 timeouts and saturates at 255 on a long run.
4. Assert good exactly on the 64th WAIT_READY cycle -> state=3, no increment. Pulse clear_count in the same cycle as an increment -> reset_count=0.
5. Deassert enable while in LINK_UP -> next cycle state=0, xcvr_reset=1, link_up=0, count unchanged. Re-enable -> a 16-cycle RST, then the link recovers.
6. Assert reset mid-RST and mid-LINK_UP -> next cycle state=1, reset_count=0, timer restarts, and a full 16-cycle pulse follows.

Source files
------------

// File: rtl/sdi_xcvr_rx_lock_supervisor_if.sv
// Status/control bundle between the SDI RX lock supervisor and its surroundings.
interface sdi_xcvr_rx_lock_supervisor_if;
  logic       enable;
  logic       rx_ready;
  logic       rx_is_lockedtodata;
  logic       sdi_locked;
  logic       clear_count;
  logic       xcvr_reset;
  logic       link_up;
  logic [1:0] state;
  logic [7:0] reset_count;

  modport master (
    output enable, rx_ready, rx_is_lockedtodata, sdi_locked, clear_count,
    input  xcvr_reset, link_up, state, reset_count
  );

  modport slave (
    input  enable, rx_ready, rx_is_lockedtodata, sdi_locked, clear_count,
    output xcvr_reset, link_up, state, reset_count
  );
endinterface

// File: rtl/sdi_xcvr_rx_lock_supervisor.sv
// Re-initialises the SDI RX transceiver on persistent lock loss or bring-up timeout,
// and reports link state plus a saturating retry counter.
module sdi_xcvr_rx_lock_supervisor #(
  parameter int unsigned RESET_PULSE_CYCLES   = 16,
  parameter int unsigned READY_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned LOCK_LOSS_CYCLES     = 1024,
  parameter int unsigned CNT_W                = 24
) (
  input logic                              clock,
  input logic                              reset,
  sdi_xcvr_rx_lock_supervisor_if.slave     sup_if
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRst  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StUp   = 2'd3;

  localparam logic [CNT_W-1:0] PulseLast   = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(READY_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LossLast    = CNT_W'(LOCK_LOSS_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       count_q, count_d;
  logic             xcvr_reset_q, link_up_q;
  logic             lock_meta_q, lock_s_q, sdi_meta_q, sdi_s_q;
  logic             good, incr;

  // rx_ready is already in this clock domain; only the transceiver flags are synchronised.
  assign good = sup_if.rx_ready & lock_s_q & sdi_s_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    incr    = 1'b0;
    if (!sup_if.enable) begin
      state_d = StIdle;
      timer_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StRst;
          timer_d = '0;
        end
        StRst: begin
          if (timer_q == PulseLast) begin
            state_d = StWait;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        StWait: begin
          if (good) begin
            state_d = StUp;
            timer_d = '0;
          end else if (timer_q == TimeoutLast) begin
            state_d = StRst;
            timer_d = '0;
            incr    = 1'b1;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        default: begin
          // In LINK_UP the timer is a consecutive-bad-cycle counter.
          if (good) begin
            timer_d = '0;
          end else if (timer_q == LossLast) begin
            state_d = StRst;
            timer_d = '0;
            incr    = 1'b1;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (sup_if.clear_count) begin
      count_d = '0;
    end else if (incr && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StRst;
      timer_q      <= '0;
      count_q      <= '0;
      xcvr_reset_q <= 1'b1;
      link_up_q    <= 1'b0;
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      sdi_meta_q   <= 1'b0;
      sdi_s_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      count_q      <= count_d;
      xcvr_reset_q <= (state_d == StIdle) | (state_d == StRst);
      link_up_q    <= (state_d == StUp);
      lock_meta_q  <= sup_if.rx_is_lockedtodata;
      lock_s_q     <= lock_meta_q;
      sdi_meta_q   <= sup_if.sdi_locked;
      sdi_s_q      <= sdi_meta_q;
    end
  end

  assign sup_if.state       = state_q;
  assign sup_if.xcvr_reset  = xcvr_reset_q;
  assign sup_if.link_up     = link_up_q;
  assign sup_if.reset_count = count_q;

endmodule

// File: tb/tb_sdi_xcvr_rx_lock_supervisor.sv
// Scoreboard bench: driver predicts post-edge outputs from a phase/elapsed model,
// monitor compares them one cycle at a time.
module tb_sdi_xcvr_rx_lock_supervisor;
  localparam int unsigned Pulse = 16;
  localparam int unsigned Tmo   = 64;
  localparam int unsigned Loss  = 8;

  typedef struct packed {
    logic [1:0] st;
    logic       xr;
    logic       lu;
    logic [7:0] cnt;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sdi_xcvr_rx_lock_supervisor_if bus ();

  sdi_xcvr_rx_lock_supervisor #(
    .RESET_PULSE_CYCLES  (Pulse),
    .READY_TIMEOUT_CYCLES(Tmo),
    .LOCK_LOSS_CYCLES    (Loss),
    .CNT_W               (24)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sup_if(bus)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: phase 0 idle, 1 reset pulse, 2 waiting, 3 up.
  // elapsed = cycles already completed in the pulse/wait, or current bad streak when up.
  int m_phase   = 1;
  int m_elapsed = 0;
  int m_retries = 0;
  bit lk_hist[2];
  bit sd_hist[2];

  task automatic model_step(input bit rst, en, rdy, lk, sd, clr);
    bit good, retry;
    retry = 1'b0;
    if (rst) begin
      m_phase = 1; m_elapsed = 0; m_retries = 0;
      lk_hist[0] = 0; lk_hist[1] = 0; sd_hist[0] = 0; sd_hist[1] = 0;
      return;
    end
    good = rdy && lk_hist[1] && sd_hist[1];
    lk_hist[1] = lk_hist[0]; lk_hist[0] = lk;
    sd_hist[1] = sd_hist[0]; sd_hist[0] = sd;
    if (!en) begin
      m_phase = 0; m_elapsed = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_elapsed = 0;
    end else if (m_phase == 1) begin
      m_elapsed++;
      if (m_elapsed == Pulse) begin m_phase = 2; m_elapsed = 0; end
    end else if (m_phase == 2) begin
      if (good) begin
        m_phase = 3; m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == Tmo) begin m_phase = 1; m_elapsed = 0; retry = 1'b1; end
      end
    end else begin
      if (good) m_elapsed = 0;
      else begin
        m_elapsed++;
        if (m_elapsed == Loss) begin m_phase = 1; m_elapsed = 0; retry = 1'b1; end
      end
    end
    if (clr) m_retries = 0;
    else if (retry && m_retries < 255) m_retries++;
  endtask

  task automatic drive(input bit rst, en, rdy, lk, sd, clr);
    exp_t e;
    @(negedge clock);
    reset                  = rst;
    bus.enable             = en;
    bus.rx_ready           = rdy;
    bus.rx_is_lockedtodata = lk;
    bus.sdi_locked         = sd;
    bus.clear_count        = clr;
    model_step(rst, en, rdy, lk, sd, clr);
    e.st  = 2'(m_phase);
    e.xr  = (m_phase <= 1);
    e.lu  = (m_phase == 3);
    e.cnt = 8'(m_retries);
    exp_q.push_back(e);
  endtask

  // Holds rx_ready low until the model sits on the last WAIT_READY cycle before timeout.
  task automatic run_to_timeout_edge();
    for (int i = 0; i < 400; i++) begin
      if (m_phase == 2 && m_elapsed == Tmo - 1) break;
      drive(0, 1, 0, 1, 1, 0);
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state", int'(bus.state), int'(e.st));
        check("xcvr_reset", int'(bus.xcvr_reset), int'(e.xr));
        check("link_up", int'(bus.link_up), int'(e.lu));
        check("reset_count", int'(bus.reset_count), int'(e.cnt));
      end
    end
  end

  initial begin : driver
    bus.enable = 1'b1; bus.rx_ready = 1'b1; bus.rx_is_lockedtodata = 1'b1;
    bus.sdi_locked = 1'b1; bus.clear_count = 1'b0;
    // Bring-up with everything good
    repeat (3) drive(1, 1, 1, 1, 1, 0);
    repeat (40) drive(0, 1, 1, 1, 1, 0);
    // Short sdi_locked drop survives, long one forces a retry
    repeat (Loss - 1) drive(0, 1, 1, 1, 0, 0);
    repeat (10) drive(0, 1, 1, 1, 1, 0);
    repeat (Loss + 4) drive(0, 1, 1, 1, 0, 0);
    repeat (40) drive(0, 1, 1, 1, 1, 0);
    // Ready never arrives: repeated timeouts up to saturation
    repeat (260 * (Pulse + Tmo)) drive(0, 1, 0, 1, 1, 0);
    drive(0, 1, 0, 1, 1, 1);
    // One timeout to make the count non-zero, then clear colliding with an increment
    run_to_timeout_edge();
    drive(0, 1, 0, 1, 1, 0);
    run_to_timeout_edge();
    drive(0, 1, 0, 1, 1, 1);
    // good arriving exactly on the timeout cycle
    run_to_timeout_edge();
    drive(0, 1, 1, 1, 1, 0);
    repeat (20) drive(0, 1, 1, 1, 1, 0);
    // enable dropped while up, then restored
    repeat (5) drive(0, 0, 1, 1, 1, 0);
    repeat (40) drive(0, 1, 1, 1, 1, 0);
    // reset mid-RST after a lock loss, then mid-LINK_UP
    repeat (Loss + 2) drive(0, 1, 1, 0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      if (m_phase == 1 && m_elapsed == 5) break;
      drive(0, 1, 1, 1, 1, 0);
    end
    drive(1, 1, 1, 1, 1, 0);
    repeat (40) drive(0, 1, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 1, 0);
    repeat (40) drive(0, 1, 1, 1, 1, 0);
    // Random soak
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 700) == 0, ($urandom % 80) != 0, ($urandom % 8) != 0,
            ($urandom % 24) != 0, ($urandom % 12) != 0, ($urandom % 150) == 0);
    end
    repeat (3) @(posedge clock);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
